// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    localparam int PIPE_WIDTH_DEFAULT = 32;
    localparam int PIPE_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant (registered in_ready).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = PIPE_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state_r;
    pipe_state_t      state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             load_main_s;

    assign out_valid  = (state_r != EMPTY);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;
    assign out_data   = main_r;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_r;
    logic             load_skid_s;
    logic             main_from_skid_s;

    // in_ready depends only on the state register, never on out_ready.
    assign in_ready = (state_r != FULL);

    // Next-state and register-load decode for the three-state skid buffer.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = BUSY;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        load_main_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_nxt_s = FULL;
                        load_skid_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        state_nxt_s      = BUSY;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: state_nxt_s = EMPTY;
            endcase
        end
    end

    // Skid register captures the one payload absorbed after back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_r <= RESET_VAL;
        end else if (load_skid_s) begin
            skid_r <= in_data;
        end else begin
            skid_r <= skid_r;
        end
    end

    // Main register feeds out_data; refilled from input or from the skid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r <= RESET_VAL;
        end else if (load_main_s) begin
            main_r <= in_data;
        end else if (main_from_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end
`else
    // Single entry: accept whenever empty or when the held payload leaves now.
    assign in_ready = (state_r == EMPTY) | out_ready;

    // Next-state and load decode for the single-register stage.
    always_comb begin
        state_nxt_s = state_r;
        load_main_s = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = BUSY;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (in_fire_s) begin
                        load_main_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                default: state_nxt_s = EMPTY;
            endcase
        end
    end

    // Main register feeds out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r <= RESET_VAL;
        end else if (load_main_s) begin
            main_r <= in_data;
        end else begin
            main_r <= main_r;
        end
    end
`endif

    // Stage occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .clr   (clr_cnt),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a reference occupancy model predicts handshake,
// payload order and stall counts for a default and a CNT_W=2 instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        clr_cnt;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;
    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  stall_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q[$];
    int          m_stall;
    int          m_stall2;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_in_ready(input bit ordy);
        if (CAP == 2) return (q.size() < 2);
        else return (q.size() == 0) || ordy;
    endfunction

    // One clock: drive, check at negedge, update the model at posedge.
    task automatic step(input bit iv, input logic [31:0] id, input bit ordy,
                        input bit fl, input bit clr, output bit acc);
        bit rdy, fire_in, fire_out, mval;
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl; clr_cnt = clr;
        @(negedge clk);
        rdy  = model_in_ready(ordy);
        mval = (q.size() > 0);
        check_eq("out_valid", out_valid, mval);
        check_eq("in_ready", in_ready, rdy);
        check_eq("out_valid2", out_valid2, mval);
        check_eq("in_ready2", in_ready2, rdy);
        if (mval) begin
            check_eq("out_data", out_data, q[0]);
            check_eq("out_data2", out_data2, q[0]);
        end
        check_eq("stall_cnt", stall_cnt, m_stall);
        check_eq("stall_cnt2", stall_cnt2, m_stall2);
        fire_in  = iv && rdy;
        fire_out = mval && ordy;
        acc      = fire_in;
        @(posedge clk);
        if (clr) begin
            m_stall = 0; m_stall2 = 0;
        end else if (mval && !ordy) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall2 < 3) m_stall2++;
        end
        if (fl) begin
            q.delete();
        end else begin
            if (fire_out) void'(q.pop_front());
            if (fire_in) q.push_back(id);
        end
        #1;
    endtask

    initial begin
        bit acc;
        int idx;
        logic [31:0] items[3];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        out_ready = 1'b0; clr_cnt = 1'b0;
        m_stall = 0; m_stall2 = 0;
        #2;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_stall_cnt", stall_cnt, 16'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Streaming at full rate
        items = '{32'h1, 32'h2, 32'h3};
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            step(1'b1, items[idx], 1'b1, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        for (int c = 0; c < 2; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        check_eq("stream_stall_cnt", stall_cnt, 16'h0);

        // Back-pressure, then release
        items = '{32'hA, 32'hB, 32'hC};
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            step(1'b1, items[idx], (c >= 4), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Fill, then flush with a concurrent input
        items = '{32'h11, 32'h22, 32'h33};
        idx = 0;
        for (int c = 0; c < 4 && q.size() < CAP; c++) begin
            step(1'b1, items[idx], 1'b0, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        step(1'b1, 32'h55, 1'b0, 1'b1, 1'b0, acc);
        for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Stall counting, clear with concurrent stall, CNT_W=2 saturation
        step(1'b1, 32'h77, 1'b1, 1'b0, 1'b1, acc);
        for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        check_eq("stall_five", stall_cnt, 16'd5);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        check_eq("stall_sat2", stall_cnt2, 2'd3);
        for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0), acc);
        end

        // Asynchronous reset between edges while payloads are held
        step(1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hDEAD0002, 1'b0, 1'b0, 1'b0, acc);
        #2; rst = 1'b1; #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_out_data", out_data, 32'h0);
        check_eq("arst_in_ready", in_ready, 1'b1);
        check_eq("arst_stall_cnt", stall_cnt, 16'h0);
        q.delete(); m_stall = 0; m_stall2 = 0;
        @(posedge clk); #1; rst = 1'b0;

        for (int c = 0; c < 40; c++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
        end
        for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
